// File: rtl/order_cmd_sched_pkg.sv
// Shared types for the order-book command scheduler: opcodes, response status codes,
// FSM state encoding and the order field width.
package order_cmd_sched_pkg;

   localparam int ORDER_W = 16;

   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_CXL = 2'b10;

   typedef enum logic [1:0] {
      ST_OK       = 2'b00,
      ST_NOT_DONE = 2'b01,
      ST_TIMEOUT  = 2'b10,
      ST_BAD_OP   = 2'b11
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_RELEASE   = 3'd3,
      S_RESPOND   = 3'd4
   } state_e;

   function automatic logic op_is_valid(input logic [1:0] op);
      return (op == OP_ADD) || (op == OP_CXL);
   endfunction

endpackage

// File: rtl/order_cmd_sched_if.sv
// Bundle of requester, engine and response signals around the command scheduler.
// The slave modport is the scheduler; master is its environment.
interface order_cmd_sched_if;
   import order_cmd_sched_pkg::*;

   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [3:0]           req_op;
   logic [31:0]          req_id;
   logic [31:0]          req_size;
   logic [31:0]          req_price;
   logic [1:0]           req_side;

   logic [ORDER_W-1:0]   eng_id;
   logic [ORDER_W-1:0]   eng_size;
   logic [ORDER_W-1:0]   eng_price;
   logic                 eng_side;

   logic                 add_start;
   logic                 add_done;
   logic [ORDER_W-1:0]   add_success;
   logic                 cxl_start;
   logic                 cxl_done;
   logic [ORDER_W-1:0]   cxl_success;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_req;
   logic [1:0]           rsp_status;
   logic [ORDER_W-1:0]   rsp_id;
   logic                 busy;

   modport slave (
      input  req_valid, req_op, req_id, req_size, req_price, req_side,
      input  add_done, add_success, cxl_done, cxl_success, rsp_ready,
      output req_ready, eng_id, eng_size, eng_price, eng_side,
      output add_start, cxl_start, rsp_valid, rsp_req, rsp_status, rsp_id, busy
   );

   modport master (
      output req_valid, req_op, req_id, req_size, req_price, req_side,
      output add_done, add_success, cxl_done, cxl_success, rsp_ready,
      input  req_ready, eng_id, eng_size, eng_price, eng_side,
      input  add_start, cxl_start, rsp_valid, rsp_req, rsp_status, rsp_id, busy
   );

endinterface

// File: rtl/order_cmd_sched_rr_arb2.sv
// Two-way round-robin pick: the pointer side wins when valid, otherwise the other side.
module order_cmd_sched_rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       ptr_i,
   output logic       grant_o,
   output logic       grant_valid_o
);

   always_comb begin
      grant_o       = ptr_i;
      grant_valid_o = |valid_i;
      if (!valid_i[ptr_i]) begin
         grant_o = ~ptr_i;
      end
   end

endmodule

// File: rtl/order_cmd_sched.sv
// Order-book front-end scheduler: arbitrates two requesters and runs one add/cancel
// engine at a time over a four-phase start/done handshake, with a hung-engine timeout.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | arbitrate, accept one command, latch its fields
// S_ISSUE     | command fields stable on eng_*, raise start of selected engine
// S_WAIT_DONE | start held high, wait for done or timeout
// S_RELEASE   | start low, wait for selected done to fall
// S_RESPOND   | rsp_valid high until rsp_ready
module order_cmd_sched
   import order_cmd_sched_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd8192
) (
   input  logic               clk,
   input  logic               rst,
   order_cmd_sched_if.slave   bus
);

   localparam logic [15:0] TO_LAST = TIMEOUT_CYCLES - 16'd1;

   state_e               state_q, state_d;
   logic                 ptr_q, ptr_d;
   logic                 req_idx_q, req_idx_d;
   logic [1:0]           op_q, op_d;
   logic [ORDER_W-1:0]   id_q, id_d;
   logic [ORDER_W-1:0]   size_q, size_d;
   logic [ORDER_W-1:0]   price_q, price_d;
   logic                 side_q, side_d;
   logic                 add_start_q, add_start_d;
   logic                 cxl_start_q, cxl_start_d;
   logic [15:0]          cnt_q, cnt_d;
   status_e              status_q, status_d;

   logic                 arb_grant;
   logic                 arb_gv;
   logic [1:0]           req_ready;
   logic [1:0]           cmd_op;
   logic [ORDER_W-1:0]   cmd_id, cmd_size, cmd_price;
   logic                 cmd_side;
   logic                 sel_done;
   logic                 sel_ok;

   order_cmd_sched_rr_arb2 u_arb (
      .valid_i       (bus.req_valid),
      .ptr_i         (ptr_q),
      .grant_o       (arb_grant),
      .grant_valid_o (arb_gv)
   );

   assign cmd_op    = arb_grant ? bus.req_op[3:2]     : bus.req_op[1:0];
   assign cmd_id    = arb_grant ? bus.req_id[31:16]   : bus.req_id[15:0];
   assign cmd_size  = arb_grant ? bus.req_size[31:16] : bus.req_size[15:0];
   assign cmd_price = arb_grant ? bus.req_price[31:16] : bus.req_price[15:0];
   assign cmd_side  = bus.req_side[arb_grant];

   // Only the engine that was started is listened to; the other one's done is ignored.
   assign sel_done = (op_q == OP_ADD) ? bus.add_done     : bus.cxl_done;
   assign sel_ok   = (op_q == OP_ADD) ? |bus.add_success : |bus.cxl_success;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= 1'b0;
         req_idx_q   <= 1'b0;
         op_q        <= 2'b00;
         id_q        <= '0;
         size_q      <= '0;
         price_q     <= '0;
         side_q      <= 1'b0;
         add_start_q <= 1'b0;
         cxl_start_q <= 1'b0;
         cnt_q       <= '0;
         status_q    <= ST_OK;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         req_idx_q   <= req_idx_d;
         op_q        <= op_d;
         id_q        <= id_d;
         size_q      <= size_d;
         price_q     <= price_d;
         side_q      <= side_d;
         add_start_q <= add_start_d;
         cxl_start_q <= cxl_start_d;
         cnt_q       <= cnt_d;
         status_q    <= status_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      req_idx_d   = req_idx_q;
      op_d        = op_q;
      id_d        = id_q;
      size_d      = size_q;
      price_d     = price_q;
      side_d      = side_q;
      add_start_d = add_start_q;
      cxl_start_d = cxl_start_q;
      cnt_d       = cnt_q;
      status_d    = status_q;
      req_ready   = 2'b00;

      case (state_q)
         S_IDLE: begin
            if (arb_gv) begin
               req_ready[arb_grant] = 1'b1;
               ptr_d     = ~arb_grant;
               req_idx_d = arb_grant;
               op_d      = cmd_op;
               id_d      = cmd_id;
               size_d    = cmd_size;
               price_d   = cmd_price;
               side_d    = cmd_side;
               if (op_is_valid(cmd_op)) begin
                  state_d = S_ISSUE;
               end else begin
                  status_d = ST_BAD_OP;
                  state_d  = S_RESPOND;
               end
            end
         end
         S_ISSUE: begin
            add_start_d = (op_q == OP_ADD);
            cxl_start_d = (op_q == OP_CXL);
            cnt_d       = '0;
            state_d     = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            cnt_d = cnt_q + 16'd1;
            if (sel_done) begin
               status_d    = sel_ok ? ST_OK : ST_NOT_DONE;
               add_start_d = 1'b0;
               cxl_start_d = 1'b0;
               state_d     = S_RELEASE;
            end else if (cnt_q == TO_LAST) begin
               status_d    = ST_TIMEOUT;
               add_start_d = 1'b0;
               cxl_start_d = 1'b0;
               state_d     = S_RELEASE;
            end
         end
         S_RELEASE: begin
            cnt_d = '0;
            if (!sel_done) begin
               state_d = S_RESPOND;
            end
         end
         S_RESPOND: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.req_ready  = req_ready;
   assign bus.eng_id     = id_q;
   assign bus.eng_size   = size_q;
   assign bus.eng_price  = price_q;
   assign bus.eng_side   = side_q;
   assign bus.add_start  = add_start_q;
   assign bus.cxl_start  = cxl_start_q;
   assign bus.rsp_valid  = (state_q == S_RESPOND);
   assign bus.rsp_req    = req_idx_q;
   assign bus.rsp_status = status_q;
   assign bus.rsp_id     = id_q;
   assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_order_cmd_sched.sv
// Directed bench for order_cmd_sched with simple add/cancel engine models.
module tb_order_cmd_sched;

   logic clk;
   logic rst;

   order_cmd_sched_if bus ();

   order_cmd_sched #(.TIMEOUT_CYCLES(16'd16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int add_lat   = 3;
   int add_stuck = 0;
   int add_cnt   = 0;
   int cxl_lat   = 1;
   int cxl_cnt   = 0;

   int add_hi  = 0;
   int cxl_hi  = 0;
   int both_hi = 0;

   // engine models: done rises after *_lat cycles of start, falls once start is low
   always @(negedge clk) begin
      if (!rst) begin
         bus.add_done = 1'b0;
         add_cnt      = 0;
      end else if (bus.add_start && !bus.add_done) begin
         if (add_stuck == 0) begin
            add_cnt++;
            if (add_cnt >= add_lat) bus.add_done = 1'b1;
         end
      end else if (!bus.add_start && bus.add_done) begin
         bus.add_done = 1'b0;
         add_cnt      = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         bus.cxl_done = 1'b0;
         cxl_cnt      = 0;
      end else if (bus.cxl_start && !bus.cxl_done) begin
         cxl_cnt++;
         if (cxl_cnt >= cxl_lat) bus.cxl_done = 1'b1;
      end else if (!bus.cxl_start && bus.cxl_done) begin
         bus.cxl_done = 1'b0;
         cxl_cnt      = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int r, input logic [1:0] op, input logic [15:0] id,
                       input logic [15:0] sz, input logic [15:0] pr, input logic sd);
      int n;
      add_hi  = 0;
      cxl_hi  = 0;
      both_hi = 0;
      bus.req_op[2*r +: 2]     = op;
      bus.req_id[16*r +: 16]   = id;
      bus.req_size[16*r +: 16] = sz;
      bus.req_price[16*r +: 16] = pr;
      bus.req_side[r]          = sd;
      bus.req_valid[r]         = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready[r] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept", {31'd0, bus.req_ready[r]}, 32'd1);
      tick();
      bus.req_valid[r] = 1'b0;
   endtask

   task automatic run_to_rsp(output int cycles);
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 100) begin
         if (bus.add_start) add_hi++;
         if (bus.cxl_start) cxl_hi++;
         if (bus.add_start && bus.cxl_start) both_hi++;
         tick();
         n++;
      end
      cycles = n;
      chk("rsp_arrives", {31'd0, bus.rsp_valid}, 32'd1);
   endtask

   task automatic retire();
      bus.rsp_ready = 1'b1;
      tick();
      chk("retire_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("retire_busy", {31'd0, bus.busy}, 32'd0);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      int   cyc;
      int   n;
      int   w;
      logic exp_r;

      rst             = 1'b0;
      bus.req_valid   = 2'b00;
      bus.req_op      = '0;
      bus.req_id      = '0;
      bus.req_size    = '0;
      bus.req_price   = '0;
      bus.req_side    = '0;
      bus.add_success = 16'd1;
      bus.cxl_success = 16'd1;
      bus.rsp_ready   = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_add_start", {31'd0, bus.add_start}, 32'd0);
      chk("rst_cxl_start", {31'd0, bus.cxl_start}, 32'd0);
      chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
      chk("rst_eng_id", {16'd0, bus.eng_id}, 32'd0);
      chk("rst_rsp_status", {30'd0, bus.rsp_status}, 32'd0);
      rst = 1'b1;
      tick();

      // T1: ADD from req0, engine done after 3 cycles
      add_lat = 3;
      bus.add_success = 16'd1;
      send(0, 2'b01, 16'd5, 16'd10, 16'd100, 1'b0);
      run_to_rsp(cyc);
      chk("t1_add_start_cycles", add_hi, 32'd3);
      chk("t1_cxl_never", cxl_hi, 32'd0);
      chk("t1_status", {30'd0, bus.rsp_status}, 32'd0);
      chk("t1_rsp_req", {31'd0, bus.rsp_req}, 32'd0);
      chk("t1_rsp_id", {16'd0, bus.rsp_id}, 32'd5);
      chk("t1_eng_size", {16'd0, bus.eng_size}, 32'd10);
      chk("t1_eng_price", {16'd0, bus.eng_price}, 32'd100);
      chk("t1_eng_side", {31'd0, bus.eng_side}, 32'd0);
      retire();

      // T2: both requesters CANCEL, 4 back-to-back pairs from reset
      do_reset();
      cxl_lat = 1;
      bus.cxl_success = 16'd1;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            bus.req_op    = 4'b1010;
            bus.req_id    = {16'd9, 16'd7};
            bus.req_size  = {16'd2, 16'd1};
            bus.req_valid = 2'b11;
         end
         add_hi  = 0;
         cxl_hi  = 0;
         both_hi = 0;
         exp_r = (k % 2 == 1);
         n = 0;
         @(negedge clk);
         while (bus.req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("t2_grant", {30'd0, bus.req_ready}, exp_r ? 32'd2 : 32'd1);
         w = bus.req_ready[1] ? 1 : 0;
         tick();
         bus.req_valid[w] = 1'b0;
         run_to_rsp(cyc);
         chk("t2_rsp_req", {31'd0, bus.rsp_req}, {31'd0, exp_r});
         chk("t2_rsp_id", {16'd0, bus.rsp_id}, exp_r ? 32'd9 : 32'd7);
         chk("t2_status", {30'd0, bus.rsp_status}, 32'd0);
         chk("t2_no_overlap", both_hi, 32'd0);
         retire();
      end

      // T3: CANCEL from req1, engine reports failure
      bus.cxl_success = 16'd0;
      send(1, 2'b10, 16'd3, 16'd4, 16'd0, 1'b1);
      run_to_rsp(cyc);
      chk("t3_status", {30'd0, bus.rsp_status}, 32'd1);
      chk("t3_rsp_id", {16'd0, bus.rsp_id}, 32'd3);
      chk("t3_rsp_req", {31'd0, bus.rsp_req}, 32'd1);
      chk("t3_add_never", add_hi, 32'd0);
      retire();
      bus.cxl_success = 16'd1;

      // T4: invalid opcode
      send(0, 2'b11, 16'h44, 16'd1, 16'd1, 1'b0);
      run_to_rsp(cyc);
      chk("t4_latency", cyc, 32'd0);
      chk("t4_status", {30'd0, bus.rsp_status}, 32'd3);
      chk("t4_rsp_id", {16'd0, bus.rsp_id}, 32'h44);
      chk("t4_no_start", add_hi + cxl_hi, 32'd0);
      retire();

      // T5: add engine never answers
      add_stuck = 1;
      send(0, 2'b01, 16'h55, 16'd1, 16'd2, 1'b1);
      run_to_rsp(cyc);
      chk("t5_start_cycles", add_hi, 32'd16);
      chk("t5_status", {30'd0, bus.rsp_status}, 32'd2);
      chk("t5_start_low", {31'd0, bus.add_start}, 32'd0);
      retire();

      // T6a: reset during WAIT_DONE
      send(0, 2'b01, 16'h31, 16'd1, 16'd1, 1'b0);
      tick();
      tick();
      chk("t6_start_before", {31'd0, bus.add_start}, 32'd1);
      rst = 1'b0;
      #1;
      chk("t6_start_rst", {31'd0, bus.add_start}, 32'd0);
      chk("t6_busy_rst", {31'd0, bus.busy}, 32'd0);
      chk("t6_eng_id_rst", {16'd0, bus.eng_id}, 32'd0);
      tick();
      rst = 1'b1;
      add_stuck = 0;
      add_lat = 1;
      tick();

      // T6b: reset while a response is pending
      send(0, 2'b01, 16'h41, 16'd1, 16'd1, 1'b0);
      run_to_rsp(cyc);
      rst = 1'b0;
      #1;
      chk("t6_rsp_valid_rst", {31'd0, bus.rsp_valid}, 32'd0);
      chk("t6_busy_rst2", {31'd0, bus.busy}, 32'd0);
      chk("t6_rsp_id_rst", {16'd0, bus.rsp_id}, 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // T6c: pointer back at 0, next ADD completes
      add_hi = 0;
      cxl_hi = 0;
      bus.req_op    = 4'b0101;
      bus.req_id    = {16'h52, 16'h51};
      bus.req_valid = 2'b11;
      @(negedge clk);
      chk("t6_ptr0_grant", {30'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 2'b00;
      run_to_rsp(cyc);
      chk("t6_status", {30'd0, bus.rsp_status}, 32'd0);
      chk("t6_rsp_id", {16'd0, bus.rsp_id}, 32'h51);
      chk("t6_rsp_req", {31'd0, bus.rsp_req}, 32'd0);
      retire();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
